l9_q2: RTL and testbench
========================

L9_Q2 -- requirements
Module: l9_q2

Interface
REQ-001 The port list SHALL be declared in positional order x, clk, reset, A, B, so that positional instantiation connects correctly.
REQ-002 clk  input  1  The single clock; all state updates SHALL occur on its rising edge.
REQ-003 reset  input  1  Asynchronous, active-low reset; reset=0 SHALL clear state immediately, independent of clk.
REQ-004 x  input  1  Count-enable input, sampled on the rising clk edge.
REQ-005 A  output  1  State bit 1, the counter MSB, driven directly from a flip-flop.
REQ-006 B  output  1  State bit 0, the counter LSB, driven directly from a flip-flop.
REQ-007 The block SHALL have no parameters, since the state width is fixed at 2.

Function
REQ-008 {A,B} SHALL form a 2-bit state S; the states are S0=00, S1=01, S2=10 and S3=11.
REQ-009 On a rising clk edge with reset=1 and x=1, S SHALL advance S0->S1->S2->S3->S0, i.e. increment modulo 4.
REQ-010 On a rising clk edge with reset=1 and x=0, S SHALL hold its value.
REQ-011 Wrap-around: S3 with x=1 SHALL go to S0 on the next edge, with no flag and no saturation.
REQ-012 Latency: the effect of x SHALL be visible on A and B one clk edge after sampling, so that A and B change only on clk edges or on reset assertion.
REQ-013 The next-state equations SHALL be B+ = B xor x and A+ = A xor (x and B).
REQ-014 The outputs SHALL be Moore-type: A and B depend only on state, and x SHALL have no combinational path to A or B.
REQ-015 x changing between clk edges SHALL have no effect until the next rising edge.

Reset
REQ-016 While reset=0, A SHALL be 0 and B SHALL be 0, regardless of clk and x.
REQ-017 Reset assertion mid-count, at any state, SHALL force S0 asynchronously.
REQ-018 After reset deassertion, the first rising edge with reset=1 SHALL apply REQ-009/REQ-010 starting from S0.
REQ-019 A rising clk edge that coincides with reset=0 SHALL leave S at S0.

Structure
REQ-020 A shared package SHALL hold the state width constant (2) and the named state encodings S0..S3.
REQ-021 A single sub-module t_ff SHALL be used, instantiated twice:
  - ports: clk, reset (async active-low), T, Q
  - behaviour: Q toggles when T=1 on the rising edge
  - connections: T_B = x; T_A = x and B.
REQ-022 The block SHALL contain no latches, no clock gating and no additional clocks.

Verification
REQ-023 Hold reset=0 with x toggling and clk running -> A=0, B=0 throughout.
REQ-024 From S0 after reset release, apply x=1 for 4 consecutive edges -> {A,B} = 01, 10, 11, 00 (wrap).
REQ-025 From S2 (10), apply x=0 for 3 edges -> {A,B} stays 10.
REQ-026 From S0, apply the edge-sampled x sequence 0,1,1,0,1,1,1,0 -> {A,B} after each edge = 00, 01, 10, 10, 11, 00, 01, 01.
REQ-027 At S3, drive reset=0 between clk edges -> {A,B}=00 immediately, before the next edge; release reset, then x=1 for 1 edge -> 01.
REQ-028 Pulse x high only between rising edges, low at each edge -> {A,B} unchanged.

Source files
------------

// File: rtl/l9_q2_pkg.sv
// Shared constants for the 2-bit modulo-4 up counter built from toggle flip-flops.
package l9_q2_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S0 = 2'b00;
  localparam logic [STATE_W-1:0] S1 = 2'b01;
  localparam logic [STATE_W-1:0] S2 = 2'b10;
  localparam logic [STATE_W-1:0] S3 = 2'b11;

endpackage

// File: rtl/l9_q2_t_ff.sv
// Toggle flip-flop with asynchronous active-low clear.
module t_ff (
  input  logic clk,
  input  logic reset,
  input  logic T,
  output logic Q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) Q <= 1'b0;
    else if (T) Q <= ~Q;
  end

endmodule

// File: rtl/l9_q2.sv
// 2-bit count-enabled modulo-4 counter; {A,B} is the state and the output (Moore).
module l9_q2
  import l9_q2_pkg::*;
(
  input  logic x,
  input  logic clk,
  input  logic reset,
  output logic A,
  output logic B
);

  logic t_a;
  logic t_b;

  // Ripple-carry toggle conditions: LSB toggles on every enabled edge,
  // MSB only when the LSB is about to carry out.
  assign t_b = x;
  assign t_a = x & B;

  t_ff u_tff_b (
    .clk   (clk),
    .reset (reset),
    .T     (t_b),
    .Q     (B)
  );

  t_ff u_tff_a (
    .clk   (clk),
    .reset (reset),
    .T     (t_a),
    .Q     (A)
  );

endmodule

// File: tb/tb_l9_q2.sv
// Directed self-checking bench for the l9_q2 counter.
module tb_l9_q2;
  import l9_q2_pkg::*;

  logic clk;
  logic reset;
  logic x;
  logic A;
  logic B;

  int n_checks;
  int n_pass;
  logic [STATE_W-1:0] exp_q[$];

  l9_q2 dut (
    .x     (x),
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B)
  );

  // clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag);
    logic [STATE_W-1:0] exp;
    logic [STATE_W-1:0] obs;
    exp = exp_q.pop_front();
    obs = {A, B};
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed AB=%b expected AB=%b", tag, obs, exp);
  endtask

  // Drive x well before the edge, then sample 1 time unit after the edge.
  task automatic step(input logic xv, input logic [STATE_W-1:0] exp, input string tag);
    x = xv;
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    check(tag);
  endtask

  initial begin
    logic [7:0] seq_x;
    logic [STATE_W-1:0] seq_exp [8];
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    x        = 1'b0;

    #2;
    exp_q.push_back(S0);
    check("reset_initial");

    // held in reset with x toggling and clock running
    for (int i = 0; i < 4; i++) step(i[0], S0, "reset_hold");

    // release mid-cycle, then count through the wrap
    #3 reset = 1'b1;
    #3;
    step(1'b1, S1, "count_s1");
    step(1'b1, S2, "count_s2");
    step(1'b1, S3, "count_s3");
    step(1'b1, S0, "count_wrap");

    // reach S2, then hold for three edges
    step(1'b1, S1, "to_s2_a");
    step(1'b1, S2, "to_s2_b");
    for (int i = 0; i < 3; i++) step(1'b0, S2, "hold_s2");

    // asynchronous reset pulse between edges
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(S0);
    check("async_reset_mid");
    #2 reset = 1'b1;

    // mixed enable sequence from S0
    seq_x = 8'b0111_0110;  // applied LSB first: 0,1,1,0,1,1,1,0
    seq_exp[0] = S0; seq_exp[1] = S1; seq_exp[2] = S2; seq_exp[3] = S2;
    seq_exp[4] = S3; seq_exp[5] = S0; seq_exp[6] = S1; seq_exp[7] = S1;
    for (int i = 0; i < 8; i++) step(seq_x[i], seq_exp[i], "mixed_seq");

    // reach S3, then reset asserted between edges
    step(1'b1, S2, "to_s3_a");
    step(1'b1, S3, "to_s3_b");
    x = 1'b0;
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(S0);
    check("async_reset_s3");
    #2 reset = 1'b1;
    #1;
    step(1'b1, S1, "after_reset_s1");

    // a clock edge during reset with x=1 must leave S0
    step(1'b1, S2, "to_s2_c");
    #2 reset = 1'b0;
    step(1'b1, S0, "edge_in_reset");
    #3 reset = 1'b1;
    #2;

    // x pulsed only between edges, low at every edge
    step(1'b1, S1, "pre_glitch");
    for (int i = 0; i < 3; i++) begin
      x = 1'b0;
      #3 x = 1'b1;
      #3 x = 1'b0;
      @(posedge clk);
      #1;
      exp_q.push_back(S1);
      check("x_between_edges");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
